// File: rtl/bus_sequencer_if.sv
// bus_sequencer_if: fetch/operand requester handshakes and external memory bus pins.
interface bus_sequencer_if #(parameter int AW = 20);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [63:0]   f_rdata;
  logic [7:0]    f_rtag;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [7:0]    m_wtag;
  logic          m_ack;
  logic [63:0]   m_rdata;
  logic [7:0]    m_rtag;
  logic [63:0]   i_data;
  logic [7:0]    i_tag;
  logic [63:0]   o_ad;
  logic [7:0]    o_tag;
  logic          o_astb;
  logic          o_rd;
  logic          o_wr;
  modport slave (
    input  f_req, f_addr, m_req, m_we, m_addr, m_wdata, m_wtag, i_data, i_tag,
    output f_ack, f_rdata, f_rtag, m_ack, m_rdata, m_rtag, o_ad, o_tag, o_astb, o_rd, o_wr
  );
  modport master (
    output f_req, f_addr, m_req, m_we, m_addr, m_wdata, m_wtag, i_data, i_tag,
    input  f_ack, f_rdata, f_rtag, m_ack, m_rdata, m_rtag, o_ad, o_tag, o_astb, o_rd, o_wr
  );
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: two-way fetch/operand arbiter and transfer sequencer for the external memory bus.
// Define BUS_SEQ_RR_EN for round-robin arbitration; otherwise operand has fixed priority over fetch.
module bus_sequencer #(
  parameter int AW      = 20,
  parameter int RD_WAIT = 2
) (
  input logic            clk,
  input logic            reset,
  bus_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDONE} state_t;
  state_t        state, state_nx;
  logic          id;
  logic          we;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic [7:0]    wtag;
  logic [3:0]    cnt;
  logic          grant_m;
  logic          start;
  assign start = state == IDLE && (bus.f_req || bus.m_req);
`ifdef BUS_SEQ_RR_EN
  // last = 1 means the operand unit held the most recent grant
  logic last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last <= 1'b1;
    else if (start) last <= grant_m;
  assign grant_m = bus.m_req && (!bus.f_req || !last);
`else
  assign grant_m = bus.m_req;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ADDR : IDLE;
      ADDR:    state_nx = we ? WDATA : RWAIT;
      WDATA:   state_nx = IDLE;
      RWAIT:   state_nx = cnt == 4'd0 ? RDONE : RWAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      id          <= 1'b0;
      we          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      wtag        <= '0;
      cnt         <= '0;
      bus.f_rdata <= '0;
      bus.f_rtag  <= '0;
      bus.m_rdata <= '0;
      bus.m_rtag  <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        id    <= grant_m;
        we    <= grant_m && bus.m_we;
        addr  <= grant_m ? bus.m_addr : bus.f_addr;
        wdata <= bus.m_wdata;
        wtag  <= bus.m_wtag;
      end
      if (state == ADDR && !we) cnt <= 4'(RD_WAIT - 1);
      else if (state == RWAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      // the bus word is taken on the edge that closes the last wait cycle
      if (state == RWAIT && cnt == 4'd0) begin
        if (id) {bus.m_rdata, bus.m_rtag} <= {bus.i_data, bus.i_tag};
        else {bus.f_rdata, bus.f_rtag} <= {bus.i_data, bus.i_tag};
      end
    end
  always_comb begin
    bus.o_astb = state == ADDR;
    bus.o_rd   = (state == ADDR && !we) || state == RWAIT;
    bus.o_wr   = (state == ADDR && we) || state == WDATA;
    bus.o_ad   = state == ADDR ? 64'(addr) : state == WDATA ? wdata : 64'd0;
    bus.o_tag  = state == WDATA ? wtag : 8'd0;
    bus.f_ack  = state == RDONE && !id;
    bus.m_ack  = state == WDATA || (state == RDONE && id);
  end
endmodule
